// File: rtl/ctl_stage_regs.sv
// Purpose: carries ID-decoded controls through ID/EX, EX/MEM, MEM/WB and resolves load-use/RAW stalls, taken-branch flushes and operand forwarding.
// Latency: ID controls reach ex_* after 1 edge, mem_* after 2, wb_* after 3; pc_write/ifid_write/ifid_flush/pc_src/fwd_* are combinational from stage state.
// Backpressure: hazards drop pc_write/ifid_write and inject a bubble into ID/EX (FORWARD_EN defined: load-use only; undefined: every RAW cycle); a taken branch overrides the stall.
module ctl_stage_regs #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_RegDst,
    input  logic             id_ALUSrc,
    input  logic             id_MemtoReg,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_Branch,
    input  logic [1:0]       id_ALUOp,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             ex_ALUSrc,
    output logic             ex_MemRead,
    output logic [1:0]       ex_ALUOp,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic             pc_src,
    output logic             wb_RegWrite,
    output logic             wb_MemtoReg,
    output logic [4:0]       wb_wreg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       RegDst;
        logic       ALUSrc;
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemRead;
        logic       MemWrite;
        logic       Branch;
        logic [1:0] ALUOp;
    } ctl_t;

    ctl_t       id_ctl;
    ctl_t       ex_ctl;
    logic [4:0] ex_rd;
    logic [4:0] ex_wreg;

    logic       mem_RegWrite;
    logic       mem_MemtoReg;
    logic       mem_Branch;
    logic       mem_zero;
    logic [4:0] mem_wreg;

    logic       hazard;
    logic       squash_idex;
    logic       count_stall;

    assign id_ctl = '{RegDst:   id_RegDst,
                      ALUSrc:   id_ALUSrc,
                      MemtoReg: id_MemtoReg,
                      RegWrite: id_RegWrite,
                      MemRead:  id_MemRead,
                      MemWrite: id_MemWrite,
                      Branch:   id_Branch,
                      ALUOp:    id_ALUOp};

    assign ex_ALUSrc  = ex_ctl.ALUSrc;
    assign ex_MemRead = ex_ctl.MemRead;
    assign ex_ALUOp   = ex_ctl.ALUOp;
    assign ex_wreg    = ex_ctl.RegDst ? ex_rd : ex_rt;

`ifdef FORWARD_EN
    // Forwarding covers ALU results, so only a load consumed by the very next instruction must wait.
    assign hazard = ex_ctl.MemRead && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
`else
    // Without forwarding any pending write in EX or MEM blocks a reader; WB is covered by the write-first regfile.
    logic ex_raw;
    logic mem_raw;
    assign ex_raw  = ex_ctl.RegWrite && (ex_wreg != 5'd0) && ((ex_wreg == id_rs) || (ex_wreg == id_rt));
    assign mem_raw = mem_RegWrite && (mem_wreg != 5'd0) && ((mem_wreg == id_rs) || (mem_wreg == id_rt));
    assign hazard  = ex_raw || mem_raw;
`endif

    // A taken branch kills the instructions behind it, so the front end must move even if it was stalled.
    assign pc_src      = mem_Branch && mem_zero;
    assign ifid_flush  = pc_src;
    assign pc_write    = !hazard || pc_src;
    assign ifid_write  = !hazard || pc_src;
    assign squash_idex = hazard || pc_src;
    assign count_stall = hazard && !pc_src;

`ifdef FORWARD_EN
    // Operand source select; the younger result in EX/MEM takes priority over MEM/WB, and $0 is never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_RegWrite && (mem_wreg != 5'd0) && (mem_wreg == ex_rs)) begin
            fwd_a = 2'b10;
        end else if (wb_RegWrite && (wb_wreg != 5'd0) && (wb_wreg == ex_rs)) begin
            fwd_a = 2'b01;
        end
        if (mem_RegWrite && (mem_wreg != 5'd0) && (mem_wreg == ex_rt)) begin
            fwd_b = 2'b10;
        end else if (wb_RegWrite && (wb_wreg != 5'd0) && (wb_wreg == ex_rt)) begin
            fwd_b = 2'b01;
        end
    end
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    // ID/EX: controls become a bubble on stall or flush; register fields always load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctl <= '0;
            ex_rs  <= 5'd0;
            ex_rt  <= 5'd0;
            ex_rd  <= 5'd0;
        end else begin
            ex_ctl <= squash_idex ? ctl_t'('0) : id_ctl;
            ex_rs  <= id_rs;
            ex_rt  <= id_rt;
            ex_rd  <= id_rd;
        end
    end

    // EX/MEM: controls of the instruction behind a taken branch are cleared; zero flag and wreg always load.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_RegWrite <= 1'b0;
            mem_MemtoReg <= 1'b0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_Branch   <= 1'b0;
            mem_zero     <= 1'b0;
            mem_wreg     <= 5'd0;
        end else begin
            mem_RegWrite <= ex_ctl.RegWrite && !pc_src;
            mem_MemtoReg <= ex_ctl.MemtoReg && !pc_src;
            mem_MemRead  <= ex_ctl.MemRead && !pc_src;
            mem_MemWrite <= ex_ctl.MemWrite && !pc_src;
            mem_Branch   <= ex_ctl.Branch && !pc_src;
            mem_zero     <= ex_zero;
            mem_wreg     <= ex_wreg;
        end
    end

    // MEM/WB: write-back controls and destination advance unconditionally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_wreg     <= 5'd0;
        end else begin
            wb_RegWrite <= mem_RegWrite;
            wb_MemtoReg <= mem_MemtoReg;
            wb_wreg     <= mem_wreg;
        end
    end

    // Event counters stick at all-ones; a stall overridden by a flush is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (count_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pc_src && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ctl_stage_regs.sv
// Purpose: self-checking bench for ctl_stage_regs with directed hazard scenarios and a randomized run against an instruction-level model.
// Latency: model advances one stage per clock; outputs are sampled 1 time unit after the falling edge.
// Backpressure: the bench holds the ID instruction whenever the model says the front end is stalled.
module tb_ctl_stage_regs;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef FORWARD_EN
    localparam bit FWD        = 1'b1;
    localparam int LU_STALLS  = 1;
    localparam int RAW_STALLS = 0;
`else
    localparam bit FWD        = 1'b0;
    localparam int LU_STALLS  = 2;
    localparam int RAW_STALLS = 2;
`endif

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       ex_zero = 1'b0;
    instr_t     id_i    = '0;

    logic             ex_ALUSrc, ex_MemRead, mem_MemRead, mem_MemWrite, pc_src;
    logic             wb_RegWrite, wb_MemtoReg, pc_write, ifid_write, ifid_flush;
    logic [1:0]       ex_ALUOp, fwd_a, fwd_b;
    logic [4:0]       ex_rs, ex_rt, wb_wreg;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: which instruction sits in each stage, plus the counters.
    instr_t           m_ex       = '0;
    instr_t           m_mem      = '0;
    instr_t           m_wb       = '0;
    logic [4:0]       m_mem_wreg = '0;
    logic [4:0]       m_wb_wreg  = '0;
    logic             m_mem_zero = 1'b0;
    logic [CNT_W-1:0] m_stall    = '0;
    logic [CNT_W-1:0] m_flush    = '0;

    always #5 clk = ~clk;

    ctl_stage_regs #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_RegDst(id_i.regdst), .id_ALUSrc(id_i.alusrc), .id_MemtoReg(id_i.memtoreg),
        .id_RegWrite(id_i.regwrite), .id_MemRead(id_i.memread), .id_MemWrite(id_i.memwrite),
        .id_Branch(id_i.branch), .id_ALUOp(id_i.aluop),
        .id_rs(id_i.rs), .id_rt(id_i.rt), .id_rd(id_i.rd), .ex_zero(ex_zero),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead), .ex_ALUOp(ex_ALUOp),
        .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .pc_src(pc_src),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_wreg(wb_wreg),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t r_fmt(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        instr_t i = '0;
        i.regdst = 1'b1; i.regwrite = 1'b1; i.aluop = 2'b10;
        i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t lw(logic [4:0] rs, logic [4:0] rt);
        instr_t i = '0;
        i.alusrc = 1'b1; i.memtoreg = 1'b1; i.regwrite = 1'b1; i.memread = 1'b1;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t sw(logic [4:0] rs, logic [4:0] rt);
        instr_t i = '0;
        i.alusrc = 1'b1; i.memwrite = 1'b1;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t beq(logic [4:0] rs, logic [4:0] rt);
        instr_t i = '0;
        i.branch = 1'b1; i.aluop = 2'b01;
        i.rs = rs; i.rt = rt;
        return i;
    endfunction

    function automatic instr_t rand_instr(int max_reg);
        instr_t i;
        i = instr_t'({$urandom, $urandom});
        i.rs = 5'($urandom_range(0, max_reg));
        i.rt = 5'($urandom_range(0, max_reg));
        i.rd = 5'($urandom_range(0, max_reg));
        return i;
    endfunction

    function automatic logic [4:0] dest(instr_t i);
        return i.regdst ? i.rd : i.rt;
    endfunction

    function automatic instr_t squash(instr_t i);
        instr_t b = '0;
        b.rs = i.rs; b.rt = i.rt; b.rd = i.rd;
        return b;
    endfunction

    function automatic logic id_reads(logic [4:0] r);
        return (r != 5'd0) && ((r == id_i.rs) || (r == id_i.rt));
    endfunction

    function automatic logic exp_pc_src();
        return m_mem.branch && m_mem_zero;
    endfunction

    function automatic logic exp_hazard();
        if (FWD) return m_ex.memread && id_reads(m_ex.rt);
        return (m_ex.regwrite && id_reads(dest(m_ex))) || (m_mem.regwrite && id_reads(m_mem_wreg));
    endfunction

    function automatic logic [1:0] exp_fwd(logic [4:0] r);
        if (!FWD || r == 5'd0) return 2'b00;
        if (m_mem.regwrite && m_mem_wreg == r) return 2'b10;
        if (m_wb.regwrite && m_wb_wreg == r) return 2'b01;
        return 2'b00;
    endfunction

    // One clock: advance the model on the rising edge, return just after the falling edge.
    task automatic tick();
        logic s, p;
        s = exp_hazard();
        p = exp_pc_src();
        @(posedge clk);
        if (reset) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
            m_mem_wreg = '0; m_wb_wreg = '0; m_mem_zero = 1'b0;
            m_stall = '0; m_flush = '0;
        end else begin
            m_wb       = m_mem;
            m_wb_wreg  = m_mem_wreg;
            m_mem      = p ? squash(m_ex) : m_ex;
            m_mem_wreg = dest(m_ex);
            m_mem_zero = ex_zero;
            m_ex       = (s || p) ? squash(id_i) : id_i;
            if (p) begin
                if (m_flush != CNT_MAX) m_flush = m_flush + 1'b1;
            end else if (s) begin
                if (m_stall != CNT_MAX) m_stall = m_stall + 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Present an instruction in ID and keep it there until the model lets it enter EX.
    task automatic issue(instr_t i);
        logic held;
        id_i = i;
        for (int c = 0; c < 4; c++) begin
            held = exp_hazard() && !exp_pc_src();
            tick();
            if (!held) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; id_i = nop(); ex_zero = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            id_i = rand_instr(3); ex_zero = 1'($urandom);
            tick();
        end
        #1;
        checks++;
        if ({ex_ALUSrc, ex_MemRead, ex_ALUOp, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg, pc_src, ifid_flush} !== 10'd0) begin
            errors++; $display("FAIL reset_ctl: got %b expected 0", {ex_ALUSrc, ex_MemRead, ex_ALUOp, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg, pc_src, ifid_flush});
        end
        checks++;
        if ({ex_rs, ex_rt, wb_wreg} !== 15'd0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {ex_rs, ex_rt, wb_wreg});
        end
        checks++;
        if ({stall_cnt, flush_cnt} !== '0) begin
            errors++; $display("FAIL reset_cnt: got %h expected 0", {stall_cnt, flush_cnt});
        end
        checks++;
        if ({pc_write, ifid_write, fwd_a, fwd_b} !== 6'b110000) begin
            errors++; $display("FAIL reset_hazard: got %b expected 110000", {pc_write, ifid_write, fwd_a, fwd_b});
        end
        // Reset in the middle of a load-use stall must leave no bubble or count behind.
        reset = 1'b0;
        issue(lw(5'd2, 5'd9));
        id_i = r_fmt(5'd9, 5'd4, 5'd11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({ex_MemRead, ex_ALUSrc, ex_ALUOp, mem_MemRead, pc_write, stall_cnt} !== {6'b000001, {CNT_W{1'b0}}}) begin
            errors++; $display("FAIL reset_mid_stall: got %b expected %b", {ex_MemRead, ex_ALUSrc, ex_ALUOp, mem_MemRead, pc_write, stall_cnt}, {6'b000001, {CNT_W{1'b0}}});
        end
    endtask

    task automatic test_raw_dependency();
        int n;
        do_reset();
        issue(r_fmt(5'd1, 5'd2, 5'd8));
        id_i = r_fmt(5'd8, 5'd3, 5'd10);
        n = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (pc_write === 1'b1) break;
            n++;
            tick();
        end
        checks++;
        if (n != RAW_STALLS) begin
            errors++; $display("FAIL raw_stall_cycles: got %0d expected %0d", n, RAW_STALLS);
        end
        checks++;
        if (stall_cnt !== CNT_W'(RAW_STALLS)) begin
            errors++; $display("FAIL raw_stall_cnt: got %0d expected %0d", stall_cnt, RAW_STALLS);
        end
        tick();
        id_i = nop();
        #1;
        checks++;
        if ({ex_rs, fwd_a, fwd_b} !== {5'd8, (FWD ? 2'b10 : 2'b00), 2'b00}) begin
            errors++; $display("FAIL raw_fwd: got rs=%0d a=%b b=%b expected rs=8 a=%b b=00", ex_rs, fwd_a, fwd_b, (FWD ? 2'b10 : 2'b00));
        end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        issue(r_fmt(5'd1, 5'd2, 5'd8));
        issue(r_fmt(5'd3, 5'd4, 5'd8));
        issue(r_fmt(5'd8, 5'd8, 5'd9));
        id_i = nop();
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== (FWD ? 4'b1010 : 4'b0000)) begin
            errors++; $display("FAIL fwd_mem_priority: got %b expected %b", {fwd_a, fwd_b}, (FWD ? 4'b1010 : 4'b0000));
        end
        issue(r_fmt(5'd1, 5'd2, 5'd6));
        issue(nop());
        issue(r_fmt(5'd0, 5'd6, 5'd9));
        id_i = nop();
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== (FWD ? 4'b0001 : 4'b0000)) begin
            errors++; $display("FAIL fwd_wb: got %b expected %b", {fwd_a, fwd_b}, (FWD ? 4'b0001 : 4'b0000));
        end
        issue(r_fmt(5'd1, 5'd2, 5'd0));
        id_i = r_fmt(5'd0, 5'd0, 5'd10);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL zero_reg_no_stall: got pc_write=%b expected 1", pc_write);
        end
        tick();
        id_i = nop();
        #1;
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            errors++; $display("FAIL zero_reg_no_fwd: got %b expected 0000", {fwd_a, fwd_b});
        end
    endtask

    task automatic test_load_use();
        int n;
        do_reset();
        issue(lw(5'd2, 5'd9));
        id_i = r_fmt(5'd9, 5'd4, 5'd11);
        #1;
        checks++;
        if ({pc_write, ifid_write} !== 2'b00) begin
            errors++; $display("FAIL lu_hold: got %b expected 00", {pc_write, ifid_write});
        end
        tick();
        #1;
        checks++;
        if ({ex_ALUSrc, ex_MemRead, ex_ALUOp} !== 4'b0000) begin
            errors++; $display("FAIL lu_bubble: got %b expected 0000", {ex_ALUSrc, ex_MemRead, ex_ALUOp});
        end
        n = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (pc_write === 1'b1) break;
            n++;
            tick();
        end
        checks++;
        if (n != LU_STALLS) begin
            errors++; $display("FAIL lu_stall_cycles: got %0d expected %0d", n, LU_STALLS);
        end
        checks++;
        if (stall_cnt !== CNT_W'(LU_STALLS)) begin
            errors++; $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, LU_STALLS);
        end
        tick();
        id_i = nop();
        #1;
        checks++;
        if ({ex_ALUOp, ex_rs, fwd_a} !== {2'b10, 5'd9, (FWD ? 2'b01 : 2'b00)}) begin
            errors++; $display("FAIL lu_consumer_ex: got op=%b rs=%0d a=%b expected op=10 rs=9 a=%b", ex_ALUOp, ex_rs, fwd_a, (FWD ? 2'b01 : 2'b00));
        end
    endtask

    task automatic test_branch();
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            issue(beq(5'd1, 5'd2));
            id_i = sw(5'd3, 5'd4); ex_zero = 1'(z);
            tick();
            ex_zero = 1'b0; id_i = lw(5'd5, 5'd6);
            #1;
            checks++;
            if ({pc_src, ifid_flush, pc_write, ifid_write} !== {1'(z), 1'(z), 2'b11}) begin
                errors++; $display("FAIL br_taken_z%0d: got %b expected %b", z, {pc_src, ifid_flush, pc_write, ifid_write}, {1'(z), 1'(z), 2'b11});
            end
            tick();
            id_i = nop();
            #1;
            checks++;
            if ({mem_MemWrite, ex_MemRead, ex_ALUSrc} !== {3{1'(1 - z)}}) begin
                errors++; $display("FAIL br_squash_z%0d: got %b expected %b", z, {mem_MemWrite, ex_MemRead, ex_ALUSrc}, {3{1'(1 - z)}});
            end
            checks++;
            if (flush_cnt !== CNT_W'(z)) begin
                errors++; $display("FAIL br_flush_cnt_z%0d: got %0d expected %0d", z, flush_cnt, z);
            end
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        issue(beq(5'd1, 5'd2));
        id_i = lw(5'd2, 5'd9); ex_zero = 1'b1;
        tick();
        ex_zero = 1'b0; id_i = r_fmt(5'd9, 5'd4, 5'd11);
        #1;
        checks++;
        if ({pc_write, ifid_write, ifid_flush, pc_src} !== 4'b1111) begin
            errors++; $display("FAIL sf_front: got %b expected 1111", {pc_write, ifid_write, ifid_flush, pc_src});
        end
        tick();
        id_i = nop();
        #1;
        checks++;
        if ({stall_cnt, flush_cnt} !== {CNT_W'(0), CNT_W'(1)}) begin
            errors++; $display("FAIL sf_counters: got stall=%0d flush=%0d expected stall=0 flush=1", stall_cnt, flush_cnt);
        end
        checks++;
        if ({mem_MemRead, ex_MemRead, ex_ALUSrc, ex_ALUOp} !== 5'd0) begin
            errors++; $display("FAIL sf_squash: got %b expected 00000", {mem_MemRead, ex_MemRead, ex_ALUSrc, ex_ALUOp});
        end
    endtask

    task automatic test_saturation();
        int e7;
        e7 = 7 * LU_STALLS;
        if (e7 > 15) e7 = 15;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            issue(lw(5'd2, 5'd9));
            issue(r_fmt(5'd9, 5'd4, 5'd11));
            if (k == 6) begin
                checks++;
                if (stall_cnt !== CNT_W'(e7)) begin
                    errors++; $display("FAIL sat_partial: got %0d expected %0d", stall_cnt, e7);
                end
            end
        end
        id_i = nop();
        #1;
        checks++;
        if (stall_cnt !== CNT_MAX) begin
            errors++; $display("FAIL sat_hold: got %0d expected %0d", stall_cnt, CNT_MAX);
        end
        issue(lw(5'd2, 5'd0));
        id_i = r_fmt(5'd0, 5'd0, 5'd12);
        #1;
        checks++;
        if ({pc_write, ifid_write} !== 2'b11) begin
            errors++; $display("FAIL lw_zero_no_stall: got %b expected 11", {pc_write, ifid_write});
        end
        tick();
    endtask

    task automatic test_random();
        logic [22:0] got_c, exp_c;
        logic [7:0]  got_h, exp_h;
        logic        pw, p;
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 31) == 0);
            id_i    = rand_instr(3);
            ex_zero = 1'($urandom);
            #1;
            got_c = {ex_ALUSrc, ex_MemRead, ex_ALUOp, ex_rs, ex_rt, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg, wb_wreg};
            exp_c = {m_ex.alusrc, m_ex.memread, m_ex.aluop, m_ex.rs, m_ex.rt, m_mem.memread, m_mem.memwrite, m_wb.regwrite, m_wb.memtoreg, m_wb_wreg};
            checks++;
            if (got_c !== exp_c) begin
                errors++; $display("FAIL rand_stages cycle %0d: got %h expected %h", c, got_c, exp_c);
            end
            p     = exp_pc_src();
            pw    = !exp_hazard() || p;
            got_h = {pc_write, ifid_write, ifid_flush, pc_src, fwd_a, fwd_b};
            exp_h = {pw, pw, p, p, exp_fwd(m_ex.rs), exp_fwd(m_ex.rt)};
            checks++;
            if (got_h !== exp_h) begin
                errors++; $display("FAIL rand_hazard cycle %0d: got %b expected %b", c, got_h, exp_h);
            end
            checks++;
            if ({stall_cnt, flush_cnt} !== {m_stall, m_flush}) begin
                errors++; $display("FAIL rand_counters cycle %0d: got %h expected %h", c, {stall_cnt, flush_cnt}, {m_stall, m_flush});
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_raw_dependency();
        test_fwd_priority();
        test_load_use();
        test_branch();
        test_stall_flush();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
